call_stack: RTL
===============

Name: call_stack

Overview:
- Hardware LIFO return-address stack for the MCU control path.
- Sits between the program counter and the control unit.
  - CALL pushes the return address.
  - RET pops it back so it can be loaded into the PC.
- The stack pointer is internal: it increments on push and decrements on pop.
- Under/overflow is reported through sticky error flags.

Parameters:
- WIDTH, 10, data (address) width in bits
- DEPTH, 8, number of entries; must be >= 2
- CW, $clog2(DEPTH+1), localparam, pointer/count width

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  asynchronous reset, active-high
- DIN  input  WIDTH  data to push
- PUSH  input  1  push request, sampled on rising CLK
- POP  input  1  pop request, sampled on rising CLK
- ERR_CLR  input  1  clears the sticky error state
- DOUT  output  WIDTH  registered popped data
- DOUT_VALID  output  1  one-cycle pulse: DOUT updated by a successful pop
- FULL  output  1  count == DEPTH
- EMPTY  output  1  count == 0
- OVF  output  1  state == OVERFLOW
- UNF  output  1  state == UNDERFLOW
- COUNT  output  CW  current number of entries

Behaviour:
- Reset (async, RST=1), applied immediately:
  - count=0, DOUT=0, DOUT_VALID=0, state=OK.
  - Storage array is not reset.
- FULL, EMPTY, OVF, UNF and COUNT decode combinationally from registered state; no extra latency.
- FSM states:
  - OK: normal operation.
  - OVERFLOW: push attempted while full.
  - UNDERFLOW: pop attempted while empty.
- In OVERFLOW or UNDERFLOW:
  - PUSH and POP are ignored (count and storage frozen, DOUT held, DOUT_VALID=0).
  - The state persists until ERR_CLR=1, which returns it to OK next edge.
  - An operation presented in the same cycle as ERR_CLR is ignored.
- In OK, per rising edge:
  - PUSH only, not full: mem[count]<=DIN; count<=count+1.
  - PUSH only, full: no write; count unchanged; state<=OVERFLOW.
  - POP only, not empty: DOUT<=mem[count-1]; count<=count-1; DOUT_VALID=1 for exactly the following cycle.
  - POP only, empty: DOUT held; DOUT_VALID=0; state<=UNDERFLOW.
  - PUSH and POP together: see Optional Feature.
  - ERR_CLR while in OK has no effect.
- Pop latency: 1 cycle, POP edge to DOUT/DOUT_VALID.
- DOUT_VALID is 0 on every cycle not following a successful pop.
- DOUT holds its last value between pops.
- Count never wraps; the range 0..DEPTH is enforced by the full/empty checks.
- Reset asserted mid-operation discards any pending pop result; DOUT_VALID=0 immediately.

Optional Feature:
- Macro: CALL_STACK_XCHG_EN.
- Defined: PUSH+POP in the same cycle is an exchange, valid whenever not empty.
  - DOUT<=mem[count-1]; mem[count-1]<=DIN; DOUT_VALID=1; count unchanged.
  - Exchange on empty: treated as POP on empty, giving UNDERFLOW.
- Undefined: PUSH+POP in the same cycle executes the pop only.
  - PUSH is silently dropped; no error is raised.

Decomposition:
- Shared package mcu_pkg holds:
  - typedef enum logic [1:0] {STK_OK, STK_OVERFLOW, STK_UNDERFLOW} stk_state_t.
  - Default localparams STK_WIDTH=10, STK_DEPTH=8.
- One sub-module is natural: stack_ram.
  - Single write port, one registered read port, WIDTH x DEPTH, no reset.
- Pointer, FSM and flags stay in call_stack.

Test Plan (WIDTH=10, DEPTH=4):
- Reset, then push 0x011, 0x022, 0x033 and pop three times -> DOUT 0x033, 0x022, 0x011, each with a DOUT_VALID pulse one cycle after its POP; EMPTY=1, COUNT=0 at end.
- Push 4 values -> FULL=1, COUNT=4; 5th push -> OVF=1, COUNT stays 4; POP while OVF -> ignored, DOUT_VALID=0; ERR_CLR -> OVF=0; POP -> top value returned.
- POP on empty after reset -> UNF=1, DOUT=0, DOUT_VALID=0; ERR_CLR with PUSH 0x155 same cycle -> UNF=0, COUNT=0 (push ignored).
- Push 0x0AA then PUSH+POP with DIN=0x0BB:
  - With XCHG: DOUT=0x0AA, COUNT=1, next POP gives 0x0BB.
  - Without XCHG: DOUT=0x0AA, COUNT=0.
- Push 2 values, assert RST asynchronously between edges -> COUNT=0, EMPTY=1, DOUT=0, DOUT_VALID=0 before the next CLK edge.
- Fill to 4, pop 2, push 2 more (0x3FF, 0x200) -> pops return 0x200, 0x3FF, then the original entries in reverse order; no spurious flags.

Source files
------------

// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared MCU control-path types and defaults
package mcu_pkg;

    // Return-address stack error FSM
    typedef enum logic [1:0] {
        STK_OK        = 2'd0,
        STK_OVERFLOW  = 2'd1,
        STK_UNDERFLOW = 2'd2
    } stk_state_t;

    localparam int STK_WIDTH = 10;
    localparam int STK_DEPTH = 8;

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - WIDTH x DEPTH storage, one write port, one registered read port
module stack_ram #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             RE,
    input  logic [AW-1:0]    RADDR,
    output logic [WIDTH-1:0] RDATA
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents deliberately not reset
    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[WADDR] <= WDATA;
        end
    end

    // Registered read, held when RE is low; same-address write returns old data
    always_ff @(posedge CLK) begin
        if (RE) begin
            RDATA <= mem[RADDR];
        end
    end

endmodule

// File: rtl/call_stack.sv
// rtl/call_stack.sv - LIFO return-address stack with sticky error FSM (option: CALL_STACK_XCHG_EN)
module call_stack
    import mcu_pkg::*;
#(
    parameter int WIDTH = STK_WIDTH,
    parameter int DEPTH = STK_DEPTH,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             PUSH,
    input  logic             POP,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    output logic             FULL,
    output logic             EMPTY,
    output logic             OVF,
    output logic             UNF,
    output logic [CW-1:0]    COUNT
);

    localparam int AW = $clog2(DEPTH);

    stk_state_t       state, state_nxt;
    logic [CW-1:0]    count, count_nxt, top_idx;
    logic             valid_nxt;
    logic             has_data;
    logic             ram_we, ram_re;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [WIDTH-1:0] ram_rdata;

    assign top_idx = count - CW'(1);

    assign COUNT = count;
    assign FULL  = (count == CW'(DEPTH));
    assign EMPTY = (count == '0);
    assign OVF   = (state == STK_OVERFLOW);
    assign UNF   = (state == STK_UNDERFLOW);

    // RAM read register has no reset, so mask it to zero until the first pop lands
    assign DOUT = has_data ? ram_rdata : '0;

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .CLK   (CLK),
        .WE    (ram_we),
        .WADDR (ram_waddr),
        .WDATA (DIN),
        .RE    (ram_re),
        .RADDR (ram_raddr),
        .RDATA (ram_rdata)
    );

    // Decode push/pop/exchange against the current count and error state
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        valid_nxt = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = count[AW-1:0];
        ram_raddr = top_idx[AW-1:0];
        case (state)
            STK_OK: begin
                if (POP) begin
                    if (EMPTY) begin
                        state_nxt = STK_UNDERFLOW;
                    end else begin
                        ram_re    = 1'b1;
                        valid_nxt = 1'b1;
`ifdef CALL_STACK_XCHG_EN
                        if (PUSH) begin
                            // Exchange: top is read and overwritten, depth unchanged
                            ram_we    = 1'b1;
                            ram_waddr = top_idx[AW-1:0];
                        end else begin
                            count_nxt = top_idx;
                        end
`else
                        // A simultaneous push is dropped without error
                        count_nxt = top_idx;
`endif
                    end
                end else if (PUSH) begin
                    if (FULL) begin
                        state_nxt = STK_OVERFLOW;
                    end else begin
                        ram_we    = 1'b1;
                        count_nxt = count + CW'(1);
                    end
                end
            end
            default: begin
                // Error states freeze the stack until cleared; ops this cycle are ignored
                if (ERR_CLR) begin
                    state_nxt = STK_OK;
                end
            end
        endcase
    end

    // Pointer, FSM and output-valid registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= STK_OK;
            count      <= '0;
            DOUT_VALID <= 1'b0;
            has_data   <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            DOUT_VALID <= valid_nxt;
            if (valid_nxt) begin
                has_data <= 1'b1;
            end
        end
    end

endmodule
